corelet_seq: RTL and testbench

- Instruction sequencer for one corelet tile of a weight-stationary convolution.
- Generates the 34-bit corelet instruction word cycle by cycle from a single start pulse. For each kernel position (kij) it fetches weights from xmem to L0, loads them into the MAC array, fetches activations, executes, and drains the OFIFO into pmem.
- After the last kij it replays the pmem partial sums through the SFP accumulator.
- Sits between the testbench/top-level host and the corelet plus its xmem/pmem SRAMs.

---
 rtl/corelet_seq_if.sv | 28 ++
 rtl/corelet_seq.sv | 265 ++++++++++++++++++++++++++
 tb/tb_corelet_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/corelet_seq_if.sv
// Host-side bundle of the corelet sequencer: launch/config, OFIFO status and the generated outputs.
interface corelet_seq_if #(
    parameter int unsigned aw     = 11,
    parameter int unsigned len_bw = 8
);
    logic              start;
    logic [len_bw-1:0] n_kij;
    logic [len_bw-1:0] n_x;
    logic [aw-1:0]     w_base;
    logic [aw-1:0]     x_base;
    logic [aw-1:0]     p_base;
    logic              ofifo_valid;
    logic [33:0]       inst;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic [len_bw-1:0] out_idx;

    modport master (
        output start, n_kij, n_x, w_base, x_base, p_base, ofifo_valid,
        input  inst, busy, done, out_valid, out_idx
    );

    modport slave (
        input  start, n_kij, n_x, w_base, x_base, p_base, ofifo_valid,
        output inst, busy, done, out_valid, out_idx
    );
endinterface

// File: rtl/corelet_seq.sv
// Corelet instruction sequencer: per-kij weight fetch/load, activation fetch/execute, OFIFO drain
// to pmem, then a pmem replay through the SFP accumulator.
module corelet_seq #(
    parameter int unsigned row      = 8,
    parameter int unsigned col      = 8,
    parameter int unsigned aw       = 11,
    parameter int unsigned len_bw   = 8,
    parameter int unsigned l0_depth = 64
) (
    input  logic         clk,
    input  logic         reset,
    corelet_seq_if.slave bus
);
    typedef enum logic [3:0] {
        StIdle, StWFetch, StWLoad, StWGap, StXFetch, StExec, StDrain, StAcc, StFlush
    } state_e;

    localparam logic [len_bw-1:0] ColL      = len_bw'(col);
    localparam logic [len_bw-1:0] WLoadLast = len_bw'(col + row - 1);
    localparam logic [len_bw-1:0] MaxX      = len_bw'(l0_depth);
    localparam logic [aw-1:0]     ColA      = aw'(col);
    localparam logic [33:0]       InstIdle  = 34'h1_800C_0000;

    localparam int unsigned BAcc  = 33;
    localparam int unsigned BCenP = 32;
    localparam int unsigned BWenP = 31;
    localparam int unsigned BCenX = 19;
    localparam int unsigned BOfRd = 6;
    localparam int unsigned BL0Rd = 3;
    localparam int unsigned BL0Wr = 2;
    localparam int unsigned BExec = 1;
    localparam int unsigned BLoad = 0;

    state_e            state_q, state_d;
    logic [len_bw-1:0] cnt_q, cnt_d, kij_q, kij_d, nkij_q, nkij_d, nx_q, nx_d;
    logic [len_bw-1:0] issued_q, issued_d, written_q, written_d, o_q, o_d;
    logic [aw-1:0]     wptr_q, wptr_d, xbase_q, xbase_d, pptr_q, pptr_d, pbase_q, pbase_d;
    logic [aw-1:0]     acc_base_q, acc_base_d, acc_a_q, acc_a_d;
    logic              rd_act_q, rd_act_d, rd_last_q, rd_last_d, acc_last_q, acc_last_d;
    logic [len_bw-1:0] rd_o_q, rd_o_d, acc_o_q, acc_o_d;
    logic [33:0]       inst_q, inst_d;
    logic              busy_q, busy_d, done_q, done_d, out_valid_q, out_valid_d;
    logic [len_bw-1:0] out_idx_q, out_idx_d;
    logic [len_bw-1:0] nx_in;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        kij_d       = kij_q;
        nkij_d      = nkij_q;
        nx_d        = nx_q;
        issued_d    = issued_q;
        written_d   = written_q;
        o_d         = o_q;
        wptr_d      = wptr_q;
        xbase_d     = xbase_q;
        pptr_d      = pptr_q;
        pbase_d     = pbase_q;
        acc_base_d  = acc_base_q;
        acc_a_d     = acc_a_q;
        inst_d      = InstIdle;
        busy_d      = busy_q;
        done_d      = 1'b0;
        nx_in       = (bus.n_x > MaxX) ? MaxX : bus.n_x;
        // Accumulate one cycle after each pmem read; result is final one cycle after the last acc.
        rd_act_d    = 1'b0;
        rd_last_d   = 1'b0;
        rd_o_d      = rd_o_q;
        inst_d[BAcc] = rd_act_q;
        acc_last_d  = rd_act_q && rd_last_q;
        acc_o_d     = rd_o_q;
        out_valid_d = acc_last_q;
        out_idx_d   = acc_last_q ? acc_o_q : '0;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    if (bus.n_kij == '0 || bus.n_x == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StWFetch;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        kij_d   = '0;
                        nkij_d  = bus.n_kij;
                        nx_d    = nx_in;
                        wptr_d  = bus.w_base;
                        xbase_d = bus.x_base;
                        pptr_d  = bus.p_base;
                        pbase_d = bus.p_base;
                    end
                end
            end
            StWFetch: begin
                if (cnt_q < ColL) begin
                    inst_d[BCenX] = 1'b0;
                    inst_d[17:7]  = wptr_q + aw'(cnt_q);
                end
                inst_d[BL0Wr] = (cnt_q != '0);
                if (cnt_q == ColL) begin
                    cnt_d   = '0;
                    state_d = StWLoad;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWLoad: begin
                inst_d[BLoad] = 1'b1;
                inst_d[BL0Rd] = (cnt_q < ColL);
                if (cnt_q == WLoadLast) begin
                    cnt_d   = '0;
                    state_d = StWGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWGap: begin
                state_d = StXFetch;
            end
            StXFetch: begin
                if (cnt_q < nx_q) begin
                    inst_d[BCenX] = 1'b0;
                    inst_d[17:7]  = xbase_q + aw'(cnt_q);
                end
                inst_d[BL0Wr] = (cnt_q != '0);
                if (cnt_q == nx_q) begin
                    cnt_d   = '0;
                    state_d = StExec;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StExec: begin
                inst_d[BExec] = 1'b1;
                inst_d[BL0Rd] = 1'b1;
                if (cnt_q == nx_q - 1'b1) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (bus.ofifo_valid && (issued_q != nx_q)) begin
                    inst_d[BOfRd] = 1'b1;
                    issued_d      = issued_q + 1'b1;
                end
                // Row read from the OFIFO last cycle is on its output now: store it.
                if (inst_q[BOfRd]) begin
                    inst_d[BCenP] = 1'b0;
                    inst_d[BWenP] = 1'b0;
                    inst_d[30:20] = pptr_q + aw'(written_q);
                    written_d     = written_q + 1'b1;
                    if (written_q == nx_q - 1'b1) begin
                        issued_d  = '0;
                        written_d = '0;
                        cnt_d     = '0;
                        wptr_d    = wptr_q + ColA;
                        pptr_d    = pptr_q + aw'(nx_q);
                        if (kij_q == nkij_q - 1'b1) begin
                            state_d    = StAcc;
                            o_d        = '0;
                            acc_base_d = pbase_q;
                            acc_a_d    = pbase_q;
                        end else begin
                            kij_d   = kij_q + 1'b1;
                            state_d = StWFetch;
                        end
                    end
                end
            end
            StAcc: begin
                inst_d[BCenP] = 1'b0;
                inst_d[30:20] = acc_a_q;
                rd_act_d      = 1'b1;
                rd_last_d     = (cnt_q == nkij_q - 1'b1);
                rd_o_d        = o_q;
                if (cnt_q == nkij_q - 1'b1) begin
                    cnt_d      = '0;
                    o_d        = o_q + 1'b1;
                    acc_base_d = acc_base_q + 1'b1;
                    acc_a_d    = acc_base_q + 1'b1;
                    if (o_q == nx_q - 1'b1) begin
                        state_d = StFlush;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    acc_a_d = acc_a_q + aw'(nx_q);
                end
            end
            StFlush: begin
                if (out_valid_q && (out_idx_q == nx_q - 1'b1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            kij_q       <= '0;
            nkij_q      <= '0;
            nx_q        <= '0;
            issued_q    <= '0;
            written_q   <= '0;
            o_q         <= '0;
            wptr_q      <= '0;
            xbase_q     <= '0;
            pptr_q      <= '0;
            pbase_q     <= '0;
            acc_base_q  <= '0;
            acc_a_q     <= '0;
            rd_act_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_o_q      <= '0;
            acc_last_q  <= 1'b0;
            acc_o_q     <= '0;
            inst_q      <= InstIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kij_q       <= kij_d;
            nkij_q      <= nkij_d;
            nx_q        <= nx_d;
            issued_q    <= issued_d;
            written_q   <= written_d;
            o_q         <= o_d;
            wptr_q      <= wptr_d;
            xbase_q     <= xbase_d;
            pptr_q      <= pptr_d;
            pbase_q     <= pbase_d;
            acc_base_q  <= acc_base_d;
            acc_a_q     <= acc_a_d;
            rd_act_q    <= rd_act_d;
            rd_last_q   <= rd_last_d;
            rd_o_q      <= rd_o_d;
            acc_last_q  <= acc_last_d;
            acc_o_q     <= acc_o_d;
            inst_q      <= inst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign bus.inst      = inst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
endmodule

// File: tb/tb_corelet_seq.sv
// Randomised scoreboard bench for corelet_seq: expected address/index streams are queued at start,
// a negedge monitor pops and compares whenever the DUT issues an SRAM access or an output.
module tb_corelet_seq;
    localparam logic [33:0] InstIdle = 34'h1_800C_0000;
    localparam int Col = 8;
    localparam int Row = 8;

    logic clk = 1'b0;
    logic reset;

    corelet_seq_if #(.aw(11), .len_bw(8)) bus ();

    corelet_seq #(
        .row(Row), .col(Col), .aw(11), .len_bw(8), .l0_depth(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_xa[$];
    int exp_pw[$];
    int exp_pr[$];
    int exp_oi[$];
    int exp_nk = 0;
    int ov_mode = 0;
    int done_cnt, load_cnt, exec_cnt, l0wr_cnt, l0rd_cnt, acc_run;
    bit prev_ov, prev_ofrd, prev_prd, prev_acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // OFIFO availability pattern, changed just after each active edge.
    always @(posedge clk) begin
        #1;
        case (ov_mode)
            0: bus.ofifo_valid = 1'b1;
            1: bus.ofifo_valid = 1'($urandom_range(0, 1));
            default: bus.ofifo_valid = ~bus.ofifo_valid;
        endcase
    end

    always @(negedge clk) begin
        logic [33:0] i;
        i = bus.inst;
        if (reset) begin
            prev_ov = 0; prev_ofrd = 0; prev_prd = 0; prev_acc = 0; acc_run = 0;
        end else begin
            check("ififo_bits", i[5:4], 0);
            if (i[2] || i[1]) check("l0wr_with_exec", i[2] & i[1], 0);
            if (!i[19]) begin
                check("xmem_wen", i[18], 1);
                check("xmem_rd_avail", exp_xa.size() != 0, 1);
                if (exp_xa.size() != 0) check("xmem_addr", i[17:7], exp_xa.pop_front());
            end
            if (i[6]) check("ofifo_rd_needs_valid", prev_ov, 1);
            if (!i[32] && !i[31]) begin
                check("pmem_wr_after_rd", prev_ofrd, 1);
                check("pmem_wr_avail", exp_pw.size() != 0, 1);
                if (exp_pw.size() != 0) check("pmem_wr_addr", i[30:20], exp_pw.pop_front());
            end
            if (!i[32] && i[31]) begin
                check("pmem_rd_avail", exp_pr.size() != 0, 1);
                if (exp_pr.size() != 0) check("pmem_rd_addr", i[30:20], exp_pr.pop_front());
            end
            if (prev_prd || i[33]) check("acc_lag", i[33], prev_prd);
            if (bus.out_valid) begin
                check("out_after_acc", prev_acc, 1);
                check("acc_per_out", acc_run, exp_nk);
                check("out_idx_avail", exp_oi.size() != 0, 1);
                if (exp_oi.size() != 0) check("out_idx", bus.out_idx, exp_oi.pop_front());
                acc_run = i[33] ? 1 : 0;
            end else if (i[33]) begin
                acc_run++;
            end
            if (bus.done) done_cnt++;
            if (i[0]) load_cnt++;
            if (i[1]) exec_cnt++;
            if (i[2]) l0wr_cnt++;
            if (i[3]) l0rd_cnt++;
            prev_ov = bus.ofifo_valid;
            prev_ofrd = i[6];
            prev_prd = !i[32] && i[31];
            prev_acc = i[33];
        end
    end

    task automatic clear_sb();
        exp_xa.delete(); exp_pw.delete(); exp_pr.delete(); exp_oi.delete();
        done_cnt = 0; load_cnt = 0; exec_cnt = 0; l0wr_cnt = 0; l0rd_cnt = 0;
    endtask

    // Reference: addresses straight from the address formulas, wrapped to 11 bits.
    task automatic push_expect(input int nk, input int nx, input int wb, input int xb, input int pb);
        for (int k = 0; k < nk; k++) begin
            for (int c = 0; c < Col; c++) exp_xa.push_back((wb + k * Col + c) % 2048);
            for (int j = 0; j < nx; j++) exp_xa.push_back((xb + j) % 2048);
            for (int j = 0; j < nx; j++) exp_pw.push_back((pb + k * nx + j) % 2048);
        end
        for (int o = 0; o < nx; o++) begin
            for (int k = 0; k < nk; k++) exp_pr.push_back((pb + k * nx + o) % 2048);
            exp_oi.push_back(o);
        end
    endtask

    task automatic run_cfg(input int nk, input int nx, input int wb, input int xb, input int pb,
                           input int mode, input bit hold, input bit mid_reset);
        bit got;
        @(negedge clk);
        clear_sb();
        if (nk != 0 && nx != 0) push_expect(nk, nx, wb, xb, pb);
        exp_nk = nk;
        ov_mode = mode;
        bus.n_kij = 8'(nk); bus.n_x = 8'(nx);
        bus.w_base = 11'(wb); bus.x_base = 11'(xb); bus.p_base = 11'(pb);
        bus.start = 1'b1;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        if (nk == 0 || nx == 0) begin
            check("empty_done", bus.done, 1);
            check("empty_busy", bus.busy, 0);
            check("empty_inst", bus.inst, InstIdle);
            bus.start = 1'b0;
            @(negedge clk);
            check("empty_done_pulse", bus.done, 0);
            check("empty_inst_after", bus.inst, InstIdle);
            return;
        end
        check("busy_after_start", bus.busy, 1);
        if (mid_reset) begin
            got = 0;
            for (int c = 0; c < 2000; c++) begin
                if (bus.inst[1]) begin got = 1; break; end
                @(negedge clk);
            end
            check("exec_seen", got, 1);
            #2 reset = 1'b1;
            #1;
            check("rst_inst", bus.inst, InstIdle);
            check("rst_busy", bus.busy, 0);
            check("rst_outv", bus.out_valid, 0);
            repeat (2) @(negedge clk);
            clear_sb();
            reset = 1'b0;
            return;
        end
        got = 0;
        for (int c = 0; c < 6000; c++) begin
            if (bus.done) begin got = 1; break; end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("done_seen", got, 1);
        check("busy_at_done", bus.busy, 0);
        repeat (4) @(negedge clk);
        check("done_once", done_cnt, 1);
        check("busy_after_done", bus.busy, 0);
        check("xmem_left", exp_xa.size(), 0);
        check("pmem_wr_left", exp_pw.size(), 0);
        check("pmem_rd_left", exp_pr.size(), 0);
        check("out_left", exp_oi.size(), 0);
        check("load_cycles", load_cnt, nk * (Col + Row));
        check("exec_cycles", exec_cnt, nk * nx);
        check("l0wr_cycles", l0wr_cnt, nk * (Col + nx));
        check("l0rd_cycles", l0rd_cnt, nk * (Col + nx));
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.n_kij = '0; bus.n_x = '0;
        bus.w_base = '0; bus.x_base = '0; bus.p_base = '0; bus.ofifo_valid = 1'b1;
        clear_sb();
        repeat (3) @(negedge clk);
        check("reset_inst", bus.inst, InstIdle);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_outv", bus.out_valid, 0);
        check("reset_outidx", bus.out_idx, 0);
        reset = 1'b0;

        run_cfg(1, 4, 0, 100, 0, 0, 0, 0);
        run_cfg(9, 16, 1000, 300, 2040, 1, 0, 0);
        run_cfg(2, 5, 50, 70, 90, 2, 0, 0);
        run_cfg(2, 3, 10, 20, 30, 1, 1, 0);
        run_cfg(4, 0, 10, 20, 30, 0, 0, 0);
        run_cfg(0, 4, 10, 20, 30, 0, 1, 0);
        run_cfg(3, 2, 0, 40, 0, 0, 0, 0);
        run_cfg(2, 6, 200, 400, 600, 1, 0, 1);
        run_cfg(2, 6, 200, 400, 600, 1, 0, 0);
        for (int t = 0; t < 4; t++) begin
            run_cfg($urandom_range(1, 4), $urandom_range(1, 20), $urandom_range(0, 2047),
                    $urandom_range(0, 2047), $urandom_range(0, 2047), 1, 0, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
